shim_spi_fault_ctrl: RTL and testbench

AXI-domain fault supervisor that sits directly after the SPI status synchronizer. It watches the stabilized SPI-core status flags and records sticky per-channel faults plus the first fault code. On any fault it sequences a controlled SPI shutdown (halt request, wait for spi_off, timeout) and holds the system faulted until software clears it.

---
 rtl/shim_spi_fault_pkg.sv | 23 ++
 rtl/shim_fault_prio_enc.sv | 23 ++
 rtl/shim_spi_fault_ctrl.sv | 107 ++++++++++
 tb/tb_shim_spi_fault_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/shim_spi_fault_pkg.sv
// shim_spi_fault_pkg: shared types and constants for the SPI fault supervisor
package shim_spi_fault_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT, ST_FAULTED} state_t;
    localparam int NUM_GRP = 13;
    localparam int NUM_CH  = 8;
    localparam int NUM_FLT = 97;
    localparam int GRP_W   = 4;
    localparam int CHAN_W  = 3;
    localparam int CODE_W  = 1 + GRP_W + CHAN_W;
    localparam int GRP_OVER_THRESH    = 0;
    localparam int GRP_UNDER_THRESH   = 1;
    localparam int GRP_ADC_OVF        = 2;
    localparam int GRP_ADC_UNF        = 3;
    localparam int GRP_CRC_ERR        = 4;
    localparam int GRP_FRAME_ERR      = 5;
    localparam int GRP_FIFO_OVF       = 6;
    localparam int GRP_FIFO_UNF       = 7;
    localparam int GRP_CLK_LOSS       = 8;
    localparam int GRP_CFG_ERR        = 9;
    localparam int GRP_SEQ_ERR        = 10;
    localparam int GRP_UNEXP_ADC_TRIG = 11;
    localparam int GRP_TRIG           = 12;
endpackage

// File: rtl/shim_fault_prio_enc.sv
// shim_fault_prio_enc: lowest-index-first priority encoder over the 97 fault flags,
// so lower groups win and the trigger flag (bit 96) ranks last.
module shim_fault_prio_enc
    import shim_spi_fault_pkg::*;
(
    input  logic [NUM_FLT-1:0] i_flags,
    output logic               o_found,
    output logic [GRP_W-1:0]   o_grp,
    output logic [CHAN_W-1:0]  o_chan
);
    always_comb begin
        o_found = 1'b0;
        o_grp   = '0;
        o_chan  = '0;
        for (int i = NUM_FLT - 1; i >= 0; i--) begin
            if (i_flags[i]) begin
                o_found = 1'b1;
                o_grp   = GRP_W'(i / NUM_CH);
                o_chan  = CHAN_W'(i % NUM_CH);
            end
        end
    end
endmodule

// File: rtl/shim_spi_fault_ctrl.sv
// shim_spi_fault_ctrl: sticky fault capture and controlled SPI shutdown sequencing.
// Optional SHIM_FAULT_MASK_EN adds fault_mask[12:0] to keep groups from tripping the halt.
module shim_spi_fault_ctrl
    import shim_spi_fault_pkg::*;
#(
    parameter int HALT_TIMEOUT = 1024,
    parameter int CNT_W        = 11
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               spi_off,
    input  logic [95:0]        ch_sts,
    input  logic               bad_trig_cmd,
    input  logic               start,
    input  logic               clear,
`ifdef SHIM_FAULT_MASK_EN
    input  logic [NUM_GRP-1:0] fault_mask,
`endif
    output logic               halt,
    output logic               running,
    output logic               fault,
    output logic               irq,
    output logic [NUM_FLT-1:0] sticky,
    output logic [CODE_W-1:0]  first_code,
    output logic               halt_timeout
);
    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_halt, r_running, r_fault, r_irq, r_timeout;
    logic [NUM_FLT-1:0]  r_sticky;
    logic [CODE_W-1:0]   r_code;
    logic [NUM_FLT-1:0]  w_flags, w_en, w_trip_flags;
    logic                w_trip, w_entry, w_clr, w_timeout;
    logic [GRP_W-1:0]    w_grp;
    logic [CHAN_W-1:0]   w_chan;

    assign w_flags = {bad_trig_cmd, ch_sts};
`ifdef SHIM_FAULT_MASK_EN
    always_comb begin
        w_en = '0;
        for (int i = 0; i < NUM_FLT; i++) w_en[i] = ~fault_mask[i / NUM_CH];
    end
`else
    assign w_en = '1;
`endif
    assign w_trip_flags = w_flags & w_en;

    shim_fault_prio_enc u_prio (
        .i_flags (w_trip_flags),
        .o_found (w_trip),
        .o_grp   (w_grp),
        .o_chan  (w_chan)
    );

    // clear is ignored while the halt handshake is in flight
    assign w_clr     = clear && (r_state != ST_HALT);
    assign w_timeout = (r_cnt == CNT_W'(HALT_TIMEOUT - 1));

    always_comb begin
        w_next  = r_state;
        w_entry = 1'b0;
        case (r_state)
            ST_IDLE:    w_next = (start && !spi_off && !w_trip) ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                w_entry = w_trip;
                w_next  = w_trip ? ST_HALT : (!start || spi_off) ? ST_IDLE : ST_RUN;
            end
            ST_HALT:    w_next = (spi_off || w_timeout) ? ST_FAULTED : ST_HALT;
            ST_FAULTED: w_next = (clear && spi_off) ? ST_IDLE : ST_FAULTED;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_halt    <= 1'b0;
            r_running <= 1'b0;
            r_fault   <= 1'b0;
            r_irq     <= 1'b0;
            r_timeout <= 1'b0;
            r_sticky  <= '0;
            r_code    <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (r_state == ST_HALT && w_next == ST_HALT) ? r_cnt + 1'b1 : '0;
            r_halt    <= (w_next == ST_HALT) || (w_next == ST_FAULTED);
            r_fault   <= (w_next == ST_HALT) || (w_next == ST_FAULTED);
            r_running <= (w_next == ST_RUN);
            r_irq     <= w_entry;
            r_sticky  <= w_clr ? '0 : (r_state != ST_IDLE) ? (r_sticky | w_flags) : r_sticky;
            r_code    <= (w_entry && (w_clr || !r_code[CODE_W-1])) ? {1'b1, w_grp, w_chan} :
                         w_clr ? '0 : r_code;
            r_timeout <= w_clr ? 1'b0 :
                         (r_state == ST_HALT && !spi_off && w_timeout) ? 1'b1 : r_timeout;
        end
    end

    assign halt         = r_halt;
    assign running      = r_running;
    assign fault        = r_fault;
    assign irq          = r_irq;
    assign sticky       = r_sticky;
    assign first_code   = r_code;
    assign halt_timeout = r_timeout;
endmodule

// File: tb/tb_shim_spi_fault_ctrl.sv
// tb_shim_spi_fault_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_shim_spi_fault_ctrl;
    localparam int HT = 16;

    logic        aclk = 1'b0, aresetn = 1'b0;
    logic        spi_off = 1'b0, bad_trig_cmd = 1'b0, start = 1'b0, clear = 1'b0;
    logic [95:0] ch_sts = '0;
`ifdef SHIM_FAULT_MASK_EN
    logic [12:0] fault_mask = '0;
`endif
    logic        halt, running, fault, irq, halt_timeout;
    logic [96:0] sticky;
    logic [7:0]  first_code;
    int          n_tests = 0, n_fail = 0;

    int          m_mode = 0, m_hcnt = 0;
    logic [96:0] m_sticky = '0;
    logic [7:0]  m_code = '0;
    logic        m_to = 1'b0, m_irq = 1'b0;

    always #5 aclk = ~aclk;

    shim_spi_fault_ctrl #(.HALT_TIMEOUT(HT), .CNT_W(5)) dut (
        .aclk(aclk), .aresetn(aresetn), .spi_off(spi_off), .ch_sts(ch_sts),
        .bad_trig_cmd(bad_trig_cmd), .start(start), .clear(clear),
`ifdef SHIM_FAULT_MASK_EN
        .fault_mask(fault_mask),
`endif
        .halt(halt), .running(running), .fault(fault), .irq(irq),
        .sticky(sticky), .first_code(first_code), .halt_timeout(halt_timeout)
    );

    function automatic int lowest(input logic [96:0] v);
        for (int i = 0; i < 97; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Model modes: 0 idle, 1 run, 2 halting, 3 faulted. Advances one clock.
    task automatic step();
        logic [96:0] f, t;
        logic        clr;
        int          lo;
        f = {bad_trig_cmd, ch_sts};
        t = f;
`ifdef SHIM_FAULT_MASK_EN
        for (int b = 0; b < 97; b++) if (fault_mask[b / 8]) t[b] = 1'b0;
`endif
        lo    = lowest(t);
        clr   = clear && (m_mode != 2);
        m_irq = 1'b0;
        if (m_mode == 1 && lo >= 0 && (!m_code[7] || clr)) m_code = 8'(128 + lo);
        else if (clr) m_code = '0;
        if (clr) begin m_sticky = '0; m_to = 1'b0; end
        else if (m_mode != 0) m_sticky = m_sticky | f;
        case (m_mode)
            0: if (start && !spi_off && lo < 0) m_mode = 1;
            1: if (lo >= 0) begin m_mode = 2; m_irq = 1'b1; m_hcnt = 0; end
               else if (!start || spi_off) m_mode = 0;
            2: if (spi_off) m_mode = 3;
               else if (m_hcnt == HT - 1) begin m_mode = 3; m_to = 1'b1; end
               else m_hcnt++;
            default: if (clear && spi_off) m_mode = 0;
        endcase
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        #22;
        n_tests++; if ({halt, running, fault, irq, halt_timeout} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl: got %b expected 00000", {halt, running, fault, irq, halt_timeout}); end
        n_tests++; if (sticky !== 97'b0 || first_code !== 8'h00) begin n_fail++; $display("FAIL reset_regs: got sticky %h code %h expected 0", sticky, first_code); end
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_start();
        start = 1'b1; spi_off = 1'b0;
        step();
        n_tests++; if (running !== 1'b1 || halt !== 1'b0) begin n_fail++; $display("FAIL start_run: got running %b halt %b expected 1 0", running, halt); end
        n_tests++; if (sticky !== 97'b0) begin n_fail++; $display("FAIL start_sticky: got %h expected 0", sticky); end
    endtask

    task automatic test_first_fault();
        ch_sts[29] = 1'b1;
        step();
        ch_sts = '0;
        n_tests++; if (irq !== 1'b1 || halt !== 1'b1) begin n_fail++; $display("FAIL entry_irq_halt: got irq %b halt %b expected 1 1", irq, halt); end
        n_tests++; if (first_code !== 8'h9D) begin n_fail++; $display("FAIL entry_code: got %h expected 9d", first_code); end
        n_tests++; if (sticky[29] !== 1'b1) begin n_fail++; $display("FAIL entry_sticky29: got %b expected 1", sticky[29]); end
        step();
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_pulse: got %b expected 0", irq); end
        spi_off = 1'b1;
        step();
        n_tests++; if ({halt, fault, halt_timeout} !== 3'b110) begin n_fail++; $display("FAIL faulted: got %b expected 110", {halt, fault, halt_timeout}); end
        clear = 1'b1;
        step();
        clear = 1'b0; spi_off = 1'b0;
        n_tests++; if (halt !== 1'b0 || sticky !== 97'b0 || first_code !== 8'h00) begin n_fail++; $display("FAIL clear_exit: got halt %b sticky %h code %h expected 0", halt, sticky, first_code); end
    endtask

    task automatic test_multi_fault();
        step();
        n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL rerun: got %b expected 1", running); end
        ch_sts[56] = 1'b1; ch_sts[22] = 1'b1;
        step();
        ch_sts = '0;
        n_tests++; if (first_code !== 8'h96) begin n_fail++; $display("FAIL multi_code: got %h expected 96", first_code); end
        ch_sts[0] = 1'b1;
        step();
        ch_sts = '0;
        n_tests++; if (first_code !== 8'h96 || sticky[0] !== 1'b1) begin n_fail++; $display("FAIL later_fault: got code %h sticky0 %b expected 96 1", first_code, sticky[0]); end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < 14; k++) step();
        n_tests++; if (halt_timeout !== 1'b0 || halt !== 1'b1) begin n_fail++; $display("FAIL pre_timeout: got to %b halt %b expected 0 1", halt_timeout, halt); end
        step();
        n_tests++; if ({halt_timeout, halt, fault, running} !== 4'b1110) begin n_fail++; $display("FAIL timeout: got %b expected 1110", {halt_timeout, halt, fault, running}); end
    endtask

    task automatic test_clear();
        spi_off = 1'b1; clear = 1'b1; start = 1'b0;
        step();
        clear = 1'b0; spi_off = 1'b0;
        n_tests++; if ({halt, halt_timeout} !== 2'b00 || sticky !== 97'b0 || first_code !== 8'h00) begin n_fail++; $display("FAIL clear_all: got halt %b to %b sticky %h code %h expected 0", halt, halt_timeout, sticky, first_code); end
        ch_sts = {$urandom, $urandom, $urandom} | 96'h1; bad_trig_cmd = 1'b1;
        step();
        ch_sts = '0; bad_trig_cmd = 1'b0;
        n_tests++; if (sticky !== 97'b0 || running !== 1'b0) begin n_fail++; $display("FAIL idle_no_capture: got sticky %h running %b expected 0", sticky, running); end
    endtask

    task automatic test_idle_block();
        start = 1'b1;
        ch_sts[$urandom_range(95)] = 1'b1;
        for (int k = 0; k < 3; k++) step();
        n_tests++; if (running !== 1'b0 || sticky !== 97'b0) begin n_fail++; $display("FAIL idle_block: got running %b sticky %h expected 0", running, sticky); end
        ch_sts = '0;
        step();
        n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL unblock: got %b expected 1", running); end
        start = 1'b0;
        step();
        n_tests++; if (running !== 1'b0 || fault !== 1'b0 || first_code !== 8'h00) begin n_fail++; $display("FAIL stop_clean: got running %b fault %b code %h expected 0", running, fault, first_code); end
    endtask

`ifdef SHIM_FAULT_MASK_EN
    task automatic test_mask();
        start = 1'b1;
        step();
        fault_mask = 13'h1000; bad_trig_cmd = 1'b1;
        step();
        n_tests++; if (sticky[96] !== 1'b1 || irq !== 1'b0 || running !== 1'b1) begin n_fail++; $display("FAIL mask_trig: got sticky96 %b irq %b running %b expected 1 0 1", sticky[96], irq, running); end
        bad_trig_cmd = 1'b0; fault_mask = '0; start = 1'b0;
        step();
    endtask
`endif

    task automatic test_random();
        int idx;
        for (int n = 0; n < 3000; n++) begin
            start   = ($urandom_range(15) != 0);
            spi_off = (m_mode >= 2) ? ($urandom_range(19) == 0) : ($urandom_range(29) == 0);
            clear   = ($urandom_range(11) == 0);
            ch_sts = '0; bad_trig_cmd = 1'b0;
            if ($urandom_range(9) == 0) begin
                for (int j = 0; j <= int'($urandom_range(2)); j++) begin
                    idx = $urandom_range(96);
                    if (idx == 96) bad_trig_cmd = 1'b1; else ch_sts[idx] = 1'b1;
                end
            end
`ifdef SHIM_FAULT_MASK_EN
            fault_mask = ($urandom_range(3) == 0) ? 13'($urandom) : 13'h0;
`endif
            step();
            n_tests++; if ({halt, running, fault, irq, halt_timeout} !== {m_mode >= 2, m_mode == 1, m_mode >= 2, m_irq, m_to}) begin n_fail++; $display("FAIL rnd_ctl @%0d: got %b expected %b", n, {halt, running, fault, irq, halt_timeout}, {m_mode >= 2, m_mode == 1, m_mode >= 2, m_irq, m_to}); end
            n_tests++; if (sticky !== m_sticky) begin n_fail++; $display("FAIL rnd_sticky @%0d: got %h expected %h", n, sticky, m_sticky); end
            n_tests++; if (first_code !== m_code) begin n_fail++; $display("FAIL rnd_code @%0d: got %h expected %h", n, first_code, m_code); end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_first_fault();
        test_multi_fault();
        test_timeout();
        test_clear();
        test_idle_block();
`ifdef SHIM_FAULT_MASK_EN
        test_mask();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
